// File: rtl/rom2ram_copy_ctrl.sv
// One-shot ROM-to-RAM copy sequencer with optional read-back verify.
// Both memories are external with 1-cycle synchronous read latency.
module rom2ram_copy_ctrl #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              verify_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   err_cnt,
    output logic              err_flag
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   ErrMax   = '1;

    typedef enum logic [1:0] {StIdle, StCopy, StVerify, StDone} state_e;

    state_e            state_q;
    logic              verify_q;
    logic              drain_q;   // issue phase finished, last read data still in flight
    logic              cmp_q;     // read data for a verify compare is valid this cycle
    logic [DATA_W-1:0] din_hold_q;
    logic [ADDR_W:0]   err_cnt_d;

    // ROM data is forwarded straight to the RAM while writing; otherwise the
    // last written word is held so ram_din stays stable.
    assign ram_din = ram_we ? rom_data : din_hold_q;

    always_comb begin
        err_cnt_d = err_cnt;
        if (cmp_q && (rom_data != ram_dout) && (err_cnt != ErrMax)) begin
            err_cnt_d = err_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            verify_q   <= 1'b0;
            drain_q    <= 1'b0;
            cmp_q      <= 1'b0;
            din_hold_q <= '0;
            rom_addr   <= '0;
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_cnt    <= '0;
            err_flag   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (ram_we) begin
                din_hold_q <= rom_data;
            end
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q  <= StCopy;
                        busy     <= 1'b1;
                        verify_q <= verify_en;
                        err_cnt  <= '0;
                        err_flag <= 1'b0;
                        rom_addr <= '0;
                        ram_addr <= '0;
                        drain_q  <= 1'b0;
                    end
                end
                StCopy: begin
                    if (!drain_q) begin
                        ram_we   <= 1'b1;
                        ram_addr <= rom_addr;
                        if (rom_addr == LastAddr) begin
                            drain_q <= 1'b1;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                        end
                    end else begin
                        ram_we   <= 1'b0;
                        drain_q  <= 1'b0;
                        cmp_q    <= 1'b0;
                        rom_addr <= '0;
                        ram_addr <= '0;
                        if (verify_q) begin
                            state_q <= StVerify;
                        end else begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                StVerify: begin
                    err_cnt <= err_cnt_d;
                    if (!drain_q) begin
                        cmp_q <= 1'b1;
                        if (rom_addr == LastAddr) begin
                            drain_q <= 1'b1;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            ram_addr <= ram_addr + 1'b1;
                        end
                    end else begin
                        state_q  <= StDone;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        err_flag <= (err_cnt_d != '0);
                        drain_q  <= 1'b0;
                        cmp_q    <= 1'b0;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom2ram_copy_ctrl.sv
// Scoreboard bench for rom2ram_copy_ctrl: stimulus queues expected RAM writes
// and done events; a negedge monitor pops and compares them.
module tb_rom2ram_copy_ctrl;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              verify_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   err_cnt;
    logic              err_flag;

    rom2ram_copy_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .verify_en (verify_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .busy      (busy),
        .done      (done),
        .err_cnt   (err_cnt),
        .err_flag  (err_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: ROM[k] = k + 0x10; RAM can corrupt words 3 and 9 on read.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic              force_err = 1'b0;

    always @(posedge clk) begin
        rom_data <= rom_addr + 8'h10;
        if (ram_we) mem[ram_addr] <= ram_din;
        if (force_err && (ram_addr == 8'd3 || ram_addr == 8'd9)) ram_dout <= 8'hFF;
        else ram_dout <= mem[ram_addr];
    end

    typedef struct {
        int c;
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int c;
        int ecnt;
        int eflag;
    } dn_t;

    wr_t wr_q[$];
    dn_t dn_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_we) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 32'(ram_we), 32'd0);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("wr_cycle", cyc, e.c);
                    check("wr_addr", 32'(ram_addr), e.addr);
                    check("wr_data", 32'(ram_din), e.data);
                end
            end
            if (done) begin
                if (dn_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    dn_t d;
                    d = dn_q.pop_front();
                    check("done_cycle", cyc, d.c);
                    check("done_err_cnt", 32'(err_cnt), d.ecnt);
                    check("done_err_flag", 32'(err_flag), d.eflag);
                    check("done_busy_low", 32'(busy), 32'd0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    // Pushes expectations and pulses start; returns the start cycle.
    task automatic issue(input logic ver, input int nwr, input logic exp_done,
                         input int ecnt, output int s);
        s = cyc;
        check("idle_busy", 32'(busy), 32'd0);
        for (int k = 0; k < nwr; k++) wr_q.push_back('{s + 2 + k, k, k + 16});
        if (exp_done) dn_q.push_back('{ver ? s + 2*DEPTH + 3 : s + DEPTH + 2, ecnt, ecnt != 0});
        start     = 1'b1;
        verify_en = ver;
        step();
        start     = 1'b0;
        verify_en = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("err_cnt_cleared", 32'(err_cnt), 32'd0);
    endtask

    int s;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        verify_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_din", 32'(ram_din), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_err_flag", 32'(err_flag), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (2) step();

        // Plain copy, then copy + clean verify, then verify with two bad words.
        issue(1'b0, DEPTH, 1'b1, 0, s);
        wait_until(s + DEPTH + 4);
        issue(1'b1, DEPTH, 1'b1, 0, s);
        wait_until(s + 2*DEPTH + 5);
        force_err = 1'b1;
        issue(1'b1, DEPTH, 1'b1, 2, s);
        wait_until(s + 2*DEPTH + 5);
        force_err = 1'b0;
        repeat (5) step();
        check("err_cnt_hold", 32'(err_cnt), 32'd2);
        check("err_flag_hold", 32'(err_flag), 32'd1);

        // Stray starts (with verify_en high) during COPY must be ignored.
        issue(1'b0, DEPTH, 1'b1, 0, s);
        check("err_flag_cleared", 32'(err_flag), 32'd0);
        wait_until(s + 5);
        start = 1'b1; verify_en = 1'b1; step(); start = 1'b0; verify_en = 1'b0;
        wait_until(s + 17);
        start = 1'b1; verify_en = 1'b1; step(); start = 1'b0; verify_en = 1'b0;
        wait_until(s + 2*DEPTH + 8);

        // Reset during write cycle 7: only writes 0..6 land, no done.
        issue(1'b0, 7, 1'b0, 0, s);
        wait_until(s + 9);
        check("pre_rst_we", 32'(ram_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_we", 32'(ram_we), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_rom_addr", 32'(rom_addr), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
        issue(1'b0, DEPTH, 1'b1, 0, s);
        wait_until(s + DEPTH + 3);

        // Back-to-back: second start in the IDLE cycle right after done.
        issue(1'b0, DEPTH, 1'b1, 0, s);
        wait_until(s + DEPTH + 3);
        issue(1'b0, DEPTH, 1'b1, 0, s);
        wait_until(s + DEPTH + 6);

        check("writes_outstanding", wr_q.size(), 32'd0);
        check("dones_outstanding", dn_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
